multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
Multi-cycle control FSM for the RV32 subset add, sub, addi, lw, sw, beq, bne and jal. It sequences fetch, decode, execute, memory and writeback over a shared instruction/data memory port with a ready handshake. It drives the same datapath selects as the single-cycle decoder (ALUsel, Asel, Bsel, Immsel, WBsel, RWen, memRW) and adds PC/IR enables, a memory-timeout fault and a retired-instruction counter. It sits between the datapath and the memory arbiter.

Parameters:
TIMEOUT, 15, max consecutive wait cycles (mem_req=1, mem_ready=0) before FAULT; legal range 1..255
COUNT_W, 16, width of instr_count; the counter wraps
TO_W, 8, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
instruction  in  32  memory read data; valid when mem_ready=1 in FETCH
zero  in  1  ALU zero flag, valid in EXEC
mem_ready  in  1  memory completes the current request this cycle
mem_req  out  1  memory request
mem_sel  out  1  0 = instruction address (PC), 1 = data address (ALU result)
memRW  out  1  0 = read, 1 = write
IRen  out  1  latch instruction into IR and current PC into oldPC
PCen  out  1  PC write enable
pc_src  out  1  0 = PC+4, 1 = ALU result
ALUsel  out  1  1 = add, 0 = sub
Asel  out  1  0 = rs1 data, 1 = oldPC
Bsel  out  1  0 = rs2 data, 1 = immediate
Immsel  out  2  00 = I, 01 = S, 10 = B, 11 = J
RWen  out  1  register file write strobe
WBsel  out  2  00 = memory data, 01 = ALU, 10 = oldPC+4
retire  out  1  one-cycle pulse when an instruction completes
instr_count  out  COUNT_W  retired-instruction count
fault  out  1  sticky fault flag
illegal_op  out  1  sticky; set when the fault cause is an unsupported opcode or funct

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, FAULT. Reset (async, rst_n=0) forces: FETCH state, IR=0, instr_count=0, timeout counter=0, fault=0, illegal_op=0.
- Outputs are combinational from state, registered IR and mem_ready. Defaults unless stated below: all strobes 0, ALUsel=1, Asel=0, Bsel=0, Immsel=00, WBsel=01, mem_sel=0, memRW=0, pc_src=0.
- FETCH: mem_req=1, mem_sel=0. When mem_ready=1: IRen=1, PCen=1 (pc_src=0), go to DECODE. Otherwise stay in FETCH.
- DECODE (1 cycle): classify IR.
  - R-type (0110011, funct3=000): funct7=0000000 is add; funct7=0100000 is sub.
  - 0010011 with funct3=000 is addi.
  - 0000011 with funct3=010 is lw.
  - 0100011 with funct3=010 is sw.
  - 1100011 with funct3=000 is beq; funct3=001 is bne.
  - 1101111 is jal.
  - Anything else: go to FAULT and set illegal_op. Otherwise go to EXEC.
- EXEC:
  - add/sub: ALUsel=1 for add, 0 for sub; Bsel=0; go to WB.
  - addi: Bsel=1, Immsel=00; go to WB.
  - lw: Bsel=1, Immsel=00; go to MEM.
  - sw: Bsel=1, Immsel=01; go to MEM.
  - beq/bne: Asel=1, Bsel=1, Immsel=10, pc_src=1. PCen=1 iff (beq and zero) or (bne and !zero). The ALU-zero comparison is resolved by the datapath. Assert retire and go to FETCH.
  - jal: Asel=1, Bsel=1, Immsel=11, pc_src=1, PCen=1; go to WB.
- MEM: mem_req=1, mem_sel=1, memRW=1 for sw, 0 for lw; ALU inputs are held as in EXEC. On mem_ready: sw asserts retire and goes to FETCH; lw goes to WB. Otherwise stay in MEM.
- WB: RWen=1 for exactly 1 cycle. WBsel=01 for add/sub/addi, 00 for lw, 10 for jal. Assert retire and go to FETCH.
- retire increments instr_count on the same edge; it wraps at 2^COUNT_W-1 to 0.
- Timeout: the counter increments each cycle with mem_req=1 and mem_ready=0, and clears on mem_ready or on a state change.
  - When the counter reaches TIMEOUT, the next state is FAULT. mem_ready on that same cycle wins (no fault).
- FAULT: all strobes 0 and mem_req=0. fault=1 is sticky; it exits only on reset.
- Reset asserted mid-transaction aborts immediately. mem_req drops asynchronously and no RWen/PCen is emitted.
- Latency with zero-wait memory:
  - add/sub/addi/jal: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq/bne: 3 cycles.

Test Plan:
- add x3,x1,x2 (0x002081B3), mem_ready held 1 -> FETCH,DECODE,EXEC,WB. RWen=1, WBsel=01, ALUsel=1 in EXEC; retire at cycle 4; instr_count=1. sub (0x402081B3) gives ALUsel=0.
- lw x2,0(x1) (0x0000A103), data mem_ready delayed 3 cycles -> MEM held 4 cycles with mem_sel=1, memRW=0. Then WB with WBsel=00, RWen=1; total 8 cycles; no fault.
- sw x2,4(x1) (0x0020A223) -> MEM with memRW=1, Immsel=01; RWen never 1; retire on mem_ready.
- beq x0,x0,8 (0x00000463) with zero=1 -> EXEC PCen=1, pc_src=1, Immsel=10. With zero=0 -> PCen=0. bne with funct3=001 inverts the condition.
- jal x1,16 (0x010000EF) -> EXEC PCen=1, pc_src=1, Immsel=11. WB has WBsel=10, RWen=1.
- 0xFFFFFFFF fetched -> FAULT after DECODE with illegal_op=1. Separately, mem_ready=0 for 15 cycles in FETCH -> fault=1, illegal_op=0, mem_req=0. Both faults are cleared only by rst_n=0.

Source files
------------

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//   Multi-cycle control FSM for the RV32 subset add, sub, addi, lw, sw, beq,
//   bne and jal. Sequences FETCH -> DECODE -> EXEC -> (MEM) -> (WB) over a
//   shared instruction/data memory port with a ready handshake, drives the
//   datapath selects, counts retired instructions and traps on illegal
//   encodings or a stalled memory.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   instruction  memory read data, sampled into IR on FETCH completion
//   zero         ALU zero flag, consulted in EXEC for branches
//   mem_ready    memory completes the current request this cycle
//   mem_req      memory request
//   mem_sel      0 = PC address, 1 = ALU result address
//   memRW        0 = read, 1 = write
//   IRen         latch instruction into IR and current PC into oldPC
//   PCen         PC write enable
//   pc_src       0 = PC+4, 1 = ALU result
//   ALUsel       1 = add, 0 = sub
//   Asel         0 = rs1, 1 = oldPC
//   Bsel         0 = rs2, 1 = immediate
//   Immsel       00 = I, 01 = S, 10 = B, 11 = J
//   RWen         register file write strobe
//   WBsel        00 = memory, 01 = ALU, 10 = oldPC+4
//   retire       one-cycle pulse when an instruction completes
//   instr_count  retired-instruction count (wraps)
//   fault        sticky fault flag, cleared only by reset
//   illegal_op   sticky, set when the fault cause is an unsupported encoding
// ---------------------------------------------------------------------------
module multicycle_control #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned COUNT_W = 16,
  parameter int unsigned TO_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        instruction,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_sel,
  output logic               memRW,
  output logic               IRen,
  output logic               PCen,
  output logic               pc_src,
  output logic               ALUsel,
  output logic               Asel,
  output logic               Bsel,
  output logic [1:0]         Immsel,
  output logic               RWen,
  output logic [1:0]         WBsel,
  output logic               retire,
  output logic [COUNT_W-1:0] instr_count,
  output logic               fault,
  output logic               illegal_op
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  state_t             state, state_nxt;
  logic [31:0]        ir;
  logic [TO_W-1:0]    to_cnt;
  logic [COUNT_W-1:0] count_q;
  logic               fault_q;
  logic               illegal_q;

  // ---------------------------------------------------------------------
  // Instruction classification from the registered IR
  // ---------------------------------------------------------------------
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       is_add, is_sub, is_addi, is_lw, is_sw, is_beq, is_bne, is_jal;
  logic       is_legal;

  // Register fields are consumed by the datapath, not by this controller.
  logic       unused_ir_fields;

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];
  assign funct7 = ir[31:25];
  assign unused_ir_fields = ^{ir[24:15], ir[11:7]};

  assign is_add  = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0000000);
  assign is_sub  = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0100000);
  assign is_addi = (opcode == 7'b0010011) && (funct3 == 3'b000);
  assign is_lw   = (opcode == 7'b0000011) && (funct3 == 3'b010);
  assign is_sw   = (opcode == 7'b0100011) && (funct3 == 3'b010);
  assign is_beq  = (opcode == 7'b1100011) && (funct3 == 3'b000);
  assign is_bne  = (opcode == 7'b1100011) && (funct3 == 3'b001);
  assign is_jal  = (opcode == 7'b1101111);

  assign is_legal = is_add | is_sub | is_addi | is_lw | is_sw |
                    is_beq | is_bne | is_jal;

  // ---------------------------------------------------------------------
  // Memory wait tracking
  // ---------------------------------------------------------------------
  logic mem_phase;
  logic mem_wait;
  logic timed_out;

  assign mem_phase = (state == S_FETCH) || (state == S_MEM);
  assign mem_wait  = mem_phase && !mem_ready;
  // This is the TIMEOUT-th consecutive wait cycle; a ready on the same
  // cycle clears mem_wait and therefore wins.
  assign timed_out = mem_wait && (to_cnt == TO_W'(TIMEOUT - 1));

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: begin
        if (mem_ready)      state_nxt = S_DECODE;
        else if (timed_out) state_nxt = S_FAULT;
      end
      S_DECODE: begin
        state_nxt = is_legal ? S_EXEC : S_FAULT;
      end
      S_EXEC: begin
        if (is_add || is_sub || is_addi || is_jal) state_nxt = S_WB;
        else if (is_lw || is_sw)                   state_nxt = S_MEM;
        else if (is_beq || is_bne)                 state_nxt = S_FETCH;
        else                                       state_nxt = S_FAULT;
      end
      S_MEM: begin
        if (mem_ready)      state_nxt = is_sw ? S_FETCH : S_WB;
        else if (timed_out) state_nxt = S_FAULT;
      end
      S_WB:    state_nxt = S_FETCH;
      S_FAULT: state_nxt = S_FAULT;
      default: state_nxt = S_FAULT;
    endcase
  end

  // ---------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------
  always_comb begin
    mem_req = 1'b0;
    mem_sel = 1'b0;
    memRW   = 1'b0;
    IRen    = 1'b0;
    PCen    = 1'b0;
    pc_src  = 1'b0;
    ALUsel  = 1'b1;
    Asel    = 1'b0;
    Bsel    = 1'b0;
    Immsel  = 2'b00;
    RWen    = 1'b0;
    WBsel   = 2'b01;
    retire  = 1'b0;

    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          IRen = 1'b1;
          PCen = 1'b1;
        end
      end
      S_EXEC: begin
        if (is_add || is_sub) begin
          ALUsel = is_add;
        end else if (is_addi || is_lw) begin
          Bsel = 1'b1;
        end else if (is_sw) begin
          Bsel   = 1'b1;
          Immsel = 2'b01;
        end else if (is_beq || is_bne) begin
          Asel   = 1'b1;
          Bsel   = 1'b1;
          Immsel = 2'b10;
          pc_src = 1'b1;
          PCen   = (is_beq && zero) || (is_bne && !zero);
          retire = 1'b1;
        end else if (is_jal) begin
          Asel   = 1'b1;
          Bsel   = 1'b1;
          Immsel = 2'b11;
          pc_src = 1'b1;
          PCen   = 1'b1;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_sel = 1'b1;
        memRW   = is_sw;
        Bsel    = 1'b1;
        Immsel  = is_sw ? 2'b01 : 2'b00;
        retire  = is_sw && mem_ready;
      end
      S_WB: begin
        RWen   = 1'b1;
        retire = 1'b1;
        if (is_lw)       WBsel = 2'b00;
        else if (is_jal) WBsel = 2'b10;
        else             WBsel = 2'b01;
      end
      default: ;
    endcase

    // While reset is held the state register already reads FETCH; mask the
    // strobes so an in-flight request is dropped without waiting for a clock.
    if (!rst_n) begin
      mem_req = 1'b0;
      IRen    = 1'b0;
      PCen    = 1'b0;
      RWen    = 1'b0;
      retire  = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // State, IR, counters and sticky flags
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      ir        <= '0;
      to_cnt    <= '0;
      count_q   <= '0;
      fault_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state <= state_nxt;

      if (IRen) ir <= instruction;

      if ((state_nxt != state) || mem_ready) to_cnt <= '0;
      else if (mem_wait)                     to_cnt <= to_cnt + TO_W'(1);

      if (retire) count_q <= count_q + COUNT_W'(1);

      if (state_nxt == S_FAULT) fault_q <= 1'b1;
      if ((state == S_DECODE) && !is_legal) illegal_q <= 1'b1;
    end
  end

  assign instr_count = count_q;
  assign fault       = fault_q;
  assign illegal_op  = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
//   Directed bench for multicycle_control. Each stimulus cycle pushes the
//   hand-derived output vector for that cycle into a scoreboard queue; an
//   independent monitor pops and compares on every falling edge.
//   COUNT_W is shrunk to 4 so the retire counter wrap is reachable.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

  localparam int unsigned CW = 4;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_ADDI = 32'h00108093;
  localparam logic [31:0] I_LW   = 32'h0000A103;
  localparam logic [31:0] I_SW   = 32'h0020A223;
  localparam logic [31:0] I_BEQ  = 32'h00000463;
  localparam logic [31:0] I_BNE  = 32'h00001463;
  localparam logic [31:0] I_JAL  = 32'h010000EF;
  localparam logic [31:0] I_ILL  = 32'hFFFFFFFF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   instruction = '0;
  logic          zero = 1'b0;
  logic          mem_ready = 1'b0;
  logic          mem_req, mem_sel, memRW, IRen, PCen, pc_src;
  logic          ALUsel, Asel, Bsel, RWen, retire, fault, illegal_op;
  logic [1:0]    Immsel, WBsel;
  logic [CW-1:0] instr_count;

  multicycle_control #(
    .TIMEOUT (15),
    .COUNT_W (CW),
    .TO_W    (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instruction (instruction),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_sel     (mem_sel),
    .memRW       (memRW),
    .IRen        (IRen),
    .PCen        (PCen),
    .pc_src      (pc_src),
    .ALUsel      (ALUsel),
    .Asel        (Asel),
    .Bsel        (Bsel),
    .Immsel      (Immsel),
    .RWen        (RWen),
    .WBsel       (WBsel),
    .retire      (retire),
    .instr_count (instr_count),
    .fault       (fault),
    .illegal_op  (illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          mem_req;
    logic          mem_sel;
    logic          memRW;
    logic          IRen;
    logic          PCen;
    logic          pc_src;
    logic          ALUsel;
    logic          Asel;
    logic          Bsel;
    logic [1:0]    Immsel;
    logic          RWen;
    logic [1:0]    WBsel;
    logic          retire;
    logic          fault;
    logic          illegal_op;
    logic [CW-1:0] cnt;
  } obs_t;

  obs_t        exp_q[$];
  string       name_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic        done = 1'b0;

  logic [CW-1:0] exp_cnt = '0;
  logic          exp_fault = 1'b0;
  logic          exp_ill = 1'b0;

  obs_t  act;
  obs_t  mon_e;
  string mon_n;

  always_comb act = {mem_req, mem_sel, memRW, IRen, PCen, pc_src, ALUsel, Asel,
                     Bsel, Immsel, RWen, WBsel, retire, fault, illegal_op,
                     instr_count};

  // Monitor: one expected vector per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      mon_n = name_q.pop_front();
      n_cmp++;
      if (act !== mon_e) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h (t=%0t)", mon_n, act, mon_e, $time);
      end
    end else if (done) begin
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Idle/default output vector.
  function automatic obs_t d();
    obs_t o;
    o        = '0;
    o.ALUsel = 1'b1;
    o.WBsel  = 2'b01;
    return o;
  endfunction

  // Drive one cycle of inputs and queue the expected outputs for it.
  task automatic step(input logic rdy, input logic z, input logic [31:0] ins,
                      input obs_t e_in, input string nm);
    obs_t e;
    e            = e_in;
    mem_ready    = rdy;
    zero         = z;
    instruction  = ins;
    e.cnt        = exp_cnt;
    e.fault      = exp_fault;
    e.illegal_op = exp_ill;
    exp_q.push_back(e);
    name_q.push_back(nm);
    if (e.retire) exp_cnt = exp_cnt + 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input int unsigned waits, input logic [31:0] ins, input string nm);
    obs_t e;
    for (int unsigned i = 0; i < waits; i++) begin
      e = d(); e.mem_req = 1'b1;
      step(1'b0, 1'b0, ins, e, {nm, "_fetch_wait"});
    end
    e = d(); e.mem_req = 1'b1; e.IRen = 1'b1; e.PCen = 1'b1;
    step(1'b1, 1'b0, ins, e, {nm, "_fetch"});
    step(1'b1, 1'b0, ins, d(), {nm, "_decode"});
  endtask

  task automatic do_reset(input string nm);
    rst_n     = 1'b0;
    exp_cnt   = '0;
    exp_fault = 1'b0;
    exp_ill   = 1'b0;
    step(1'b0, 1'b0, '0, d(), nm);
    rst_n = 1'b1;
  endtask

  task automatic run_rtype(input logic [31:0] ins, input logic alu,
                           input int unsigned fwaits, input string nm);
    obs_t e;
    fetch(fwaits, ins, nm);
    e = d(); e.ALUsel = alu;
    step(1'b1, 1'b0, ins, e, {nm, "_exec"});
    e = d(); e.RWen = 1'b1; e.WBsel = 2'b01; e.retire = 1'b1;
    step(1'b1, 1'b0, ins, e, {nm, "_wb"});
  endtask

  task automatic run_addi();
    obs_t e;
    fetch(0, I_ADDI, "addi");
    e = d(); e.Bsel = 1'b1;
    step(1'b1, 1'b0, I_ADDI, e, "addi_exec");
    e = d(); e.RWen = 1'b1; e.retire = 1'b1;
    step(1'b1, 1'b0, I_ADDI, e, "addi_wb");
  endtask

  task automatic run_lw(input int unsigned fwaits, input int unsigned mwaits);
    obs_t e;
    fetch(fwaits, I_LW, "lw");
    e = d(); e.Bsel = 1'b1;
    step(1'b1, 1'b0, I_LW, e, "lw_exec");
    e = d(); e.mem_req = 1'b1; e.mem_sel = 1'b1; e.Bsel = 1'b1;
    for (int unsigned i = 0; i < mwaits; i++) step(1'b0, 1'b0, I_LW, e, "lw_mem_wait");
    step(1'b1, 1'b0, I_LW, e, "lw_mem_done");
    e = d(); e.RWen = 1'b1; e.WBsel = 2'b00; e.retire = 1'b1;
    step(1'b1, 1'b0, I_LW, e, "lw_wb");
  endtask

  task automatic run_sw(input int unsigned mwaits);
    obs_t e;
    fetch(0, I_SW, "sw");
    e = d(); e.Bsel = 1'b1; e.Immsel = 2'b01;
    step(1'b1, 1'b0, I_SW, e, "sw_exec");
    e = d(); e.mem_req = 1'b1; e.mem_sel = 1'b1; e.memRW = 1'b1;
    e.Bsel = 1'b1; e.Immsel = 2'b01;
    for (int unsigned i = 0; i < mwaits; i++) step(1'b0, 1'b0, I_SW, e, "sw_mem_wait");
    e.retire = 1'b1;
    step(1'b1, 1'b0, I_SW, e, "sw_mem_done");
  endtask

  task automatic run_br(input logic [31:0] ins, input logic z, input logic take,
                        input string nm);
    obs_t e;
    fetch(0, ins, nm);
    e = d(); e.Asel = 1'b1; e.Bsel = 1'b1; e.Immsel = 2'b10; e.pc_src = 1'b1;
    e.PCen = take; e.retire = 1'b1;
    step(1'b1, z, ins, e, {nm, "_exec"});
  endtask

  task automatic run_jal();
    obs_t e;
    fetch(0, I_JAL, "jal");
    e = d(); e.Asel = 1'b1; e.Bsel = 1'b1; e.Immsel = 2'b11; e.pc_src = 1'b1;
    e.PCen = 1'b1;
    step(1'b1, 1'b0, I_JAL, e, "jal_exec");
    e = d(); e.RWen = 1'b1; e.WBsel = 2'b10; e.retire = 1'b1;
    step(1'b1, 1'b0, I_JAL, e, "jal_wb");
  endtask

  initial begin
    obs_t e;
    @(posedge clk);
    #1;
    do_reset("reset_initial");

    run_rtype(I_ADD, 1'b1, 0, "add");
    run_rtype(I_SUB, 1'b0, 0, "sub");
    run_addi();
    run_lw(0, 3);
    run_sw(1);
    run_br(I_BEQ, 1'b1, 1'b1, "beq_z1");
    run_br(I_BEQ, 1'b0, 1'b0, "beq_z0");
    run_br(I_BNE, 1'b0, 1'b1, "bne_z0");
    run_br(I_BNE, 1'b1, 1'b0, "bne_z1");
    run_jal();

    // 14 wait cycles then ready on the 15th: ready wins over the timeout.
    run_rtype(I_ADD, 1'b1, 14, "add_late");
    // Wait counter must restart between FETCH and MEM.
    run_lw(10, 14);

    // Retire counter 12 -> 15 -> wraps to 0 -> 1.
    run_br(I_BEQ, 1'b1, 1'b1, "beq_c13");
    run_br(I_BEQ, 1'b1, 1'b1, "beq_c14");
    run_br(I_BEQ, 1'b1, 1'b1, "beq_c15");
    run_br(I_BEQ, 1'b0, 1'b0, "beq_wrap");
    run_rtype(I_ADD, 1'b1, 0, "add_after_wrap");

    // Illegal encoding: DECODE -> FAULT, sticky.
    fetch(0, I_ILL, "ill");
    exp_fault = 1'b1;
    exp_ill   = 1'b1;
    for (int unsigned i = 0; i < 3; i++) step(1'b1, 1'b0, I_ILL, d(), "ill_fault_hold");
    n_cmp++;
    if (fault !== 1'b1) begin
      n_bad++;
      $display("FAIL ill_direct_fault: got %b expected 1", fault);
    end
    n_cmp++;
    if (illegal_op !== 1'b1) begin
      n_bad++;
      $display("FAIL ill_direct_illegal: got %b expected 1", illegal_op);
    end
    do_reset("reset_after_illegal");

    // Memory timeout in FETCH: 15 waiting cycles, then FAULT without illegal_op.
    e = d(); e.mem_req = 1'b1;
    for (int unsigned i = 0; i < 15; i++) step(1'b0, 1'b0, I_ADD, e, "to_fetch_wait");
    exp_fault = 1'b1;
    step(1'b0, 1'b0, I_ADD, d(), "to_fault");
    step(1'b1, 1'b0, I_ADD, d(), "to_fault_ready_ignored");
    step(1'b1, 1'b0, I_ADD, d(), "to_fault_hold");
    n_cmp++;
    if (fault !== 1'b1) begin
      n_bad++;
      $display("FAIL to_direct_fault: got %b expected 1", fault);
    end
    n_cmp++;
    if (illegal_op !== 1'b0) begin
      n_bad++;
      $display("FAIL to_direct_illegal: got %b expected 0", illegal_op);
    end
    n_cmp++;
    if (mem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL to_direct_mem_req: got %b expected 0", mem_req);
    end
    do_reset("reset_after_timeout");
    n_cmp++;
    if (fault !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_direct_fault: got %b expected 0", fault);
    end
    n_cmp++;
    if (illegal_op !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_direct_illegal: got %b expected 0", illegal_op);
    end
    n_cmp++;
    if (instr_count !== '0) begin
      n_bad++;
      $display("FAIL rst_direct_count: got %h expected 0", instr_count);
    end

    // Reset in the middle of a load's MEM phase aborts it.
    run_rtype(I_ADD, 1'b1, 0, "add_pre_abort");
    fetch(0, I_LW, "lw_abort");
    e = d(); e.Bsel = 1'b1;
    step(1'b1, 1'b0, I_LW, e, "lw_abort_exec");
    e = d(); e.mem_req = 1'b1; e.mem_sel = 1'b1; e.Bsel = 1'b1;
    step(1'b0, 1'b0, I_LW, e, "lw_abort_mem");
    do_reset("reset_mid_mem");
    run_rtype(I_ADD, 1'b1, 0, "add_post_abort");

    done = 1'b1;
  end

endmodule
